// File: rtl/regfile_write_sequencer_if.sv
// Write-port bus of the register-file write sequencer: the two write
// requesters, the memory stall inputs, the registered write port and
// the read-address match flags.
interface regfile_write_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  BUSYWAIT;
  logic                  IBUSYWAIT;

  logic                  A_VALID;
  logic [ADDR_WIDTH-1:0] A_ADDR;
  logic [DATA_WIDTH-1:0] A_DATA;
  logic                  A_READY;

  logic                  M_VALID;
  logic [ADDR_WIDTH-1:0] M_ADDR;
  logic [DATA_WIDTH-1:0] M_DATA;
  logic                  M_READY;

  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic [DATA_WIDTH-1:0] IN;
  logic                  INIT_DONE;

  logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
  logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
  logic                  FWD1;
  logic                  FWD2;

  // Requester / pipeline side: drives requests, stalls and read addresses.
  modport master (
    output BUSYWAIT, IBUSYWAIT,
    output A_VALID, A_ADDR, A_DATA,
    output M_VALID, M_ADDR, M_DATA,
    output OUT1ADDRESS, OUT2ADDRESS,
    input  A_READY, M_READY,
    input  WRITE, INADDRESS, IN, INIT_DONE,
    input  FWD1, FWD2
  );

  // Sequencer side: owns the register-file write port.
  modport slave (
    input  BUSYWAIT, IBUSYWAIT,
    input  A_VALID, A_ADDR, A_DATA,
    input  M_VALID, M_ADDR, M_DATA,
    input  OUT1ADDRESS, OUT2ADDRESS,
    output A_READY, M_READY,
    output WRITE, INADDRESS, IN, INIT_DONE,
    output FWD1, FWD2
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Owns the single write port of the register file. After reset it sweeps
// every register to INIT_VALUE, then arbitrates between the ALU writeback
// (A, priority) and the load path (M), forcing M through after AGE_LIMIT
// consecutive A wins. Any memory stall freezes all state.
module regfile_write_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AGE_LIMIT  = 3,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  regfile_write_sequencer_if.slave   bus
);

  localparam int unsigned AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0]      AGE_MAX   = AGE_W'(AGE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [DATA_WIDTH-1:0] INIT_DATA = DATA_WIDTH'(INIT_VALUE);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q,  init_cnt_d;
  logic [AGE_W-1:0]      age_q,       age_d;
  logic                  write_q,     write_d;
  logic [ADDR_WIDTH-1:0] inaddr_q,    inaddr_d;
  logic [DATA_WIDTH-1:0] in_q,        in_d;
  logic                  init_done_q, init_done_d;

  logic stall;
  logic grant_a;
  logic grant_m;

  // Arbitration: ALU wins unless the load requester has aged out.
  always_comb begin
    stall   = bus.BUSYWAIT | bus.IBUSYWAIT;
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!stall && (state_q == ST_RUN)) begin
      grant_a = bus.A_VALID && (!bus.M_VALID || (age_q != AGE_MAX));
      grant_m = bus.M_VALID && (!bus.A_VALID || (age_q == AGE_MAX));
    end
  end

  // Next-state: init sweep, then one write per granted request.
  always_comb begin
    // NOTE: every variable gets a hold default first, so paths that do not
    // assign it keep the flop value instead of inferring a latch.
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    age_d       = age_q;
    write_d     = write_q;
    inaddr_d    = inaddr_q;
    in_d        = in_q;
    init_done_d = init_done_q;

    if (!stall) begin
      case (state_q)
        ST_INIT: begin
          write_d    = 1'b1;
          inaddr_d   = init_cnt_q;
          in_d       = INIT_DATA;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          write_d = grant_a | grant_m;
          if (grant_a) begin
            inaddr_d = bus.A_ADDR;
            in_d     = bus.A_DATA;
          end else if (grant_m) begin
            inaddr_d = bus.M_ADDR;
            in_d     = bus.M_DATA;
          end
          // Age only counts A wins while M is waiting; any M grant or an
          // idle M clears it.
          if (grant_m || !bus.M_VALID) begin
            age_d = '0;
          end else if (grant_a && (age_q != AGE_MAX)) begin
            age_d = age_q + 1'b1;
          end
        end
      endcase
    end
  end

  // State and registered write port, asynchronously reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      age_q       <= '0;
      write_q     <= 1'b0;
      inaddr_q    <= '0;
      in_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge values computed in the combinational block.
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      age_q       <= age_d;
      write_q     <= write_d;
      inaddr_q    <= inaddr_d;
      in_q        <= in_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.A_READY   = grant_a;
  assign bus.M_READY   = grant_m;
  assign bus.WRITE     = write_q;
  assign bus.INADDRESS = inaddr_q;
  assign bus.IN        = in_q;
  assign bus.INIT_DONE = init_done_q;

  // Read ports whose address matches the write being presented now.
  assign bus.FWD1 = write_q && (inaddr_q == bus.OUT1ADDRESS);
  assign bus.FWD2 = write_q && (inaddr_q == bus.OUT2ADDRESS);

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed testbench for regfile_write_sequencer (8x8, AGE_LIMIT=3, INIT_VALUE=0).
module tb_regfile_write_sequencer;

  logic CLK;
  logic RESET;

  regfile_write_sequencer_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  regfile_write_sequencer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AGE_LIMIT (3),
    .INIT_VALUE(0)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Packed views of the outputs: {WRITE, INADDRESS, IN, INIT_DONE}, {A_READY, M_READY}, {FWD1, FWD2}
  logic [12:0] wr_obs;
  logic [1:0]  rdy_obs;
  logic [1:0]  fwd_obs;
  assign wr_obs  = {bus.WRITE, bus.INADDRESS, bus.IN, bus.INIT_DONE};
  assign rdy_obs = {bus.A_READY, bus.M_READY};
  assign fwd_obs = {bus.FWD1, bus.FWD2};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    bus.A_VALID = 1'b1; bus.A_ADDR = 3'd1; bus.A_DATA = 8'h11;
    bus.M_VALID = 1'b1; bus.M_ADDR = 3'd2; bus.M_DATA = 8'h22;
    RESET = 1'b1;
    step();
    step();
    n_checks++;
    if (wr_obs !== 13'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", wr_obs, 13'h0);
    end
    n_checks++;
    if (fwd_obs !== 2'b00) begin
      n_fail++; $display("FAIL reset_fwd: got %b expected %b", fwd_obs, 2'b00);
    end
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rdy_obs !== 2'b00) begin
        n_fail++; $display("FAIL init_ready[%0d]: got %b expected %b", i, rdy_obs, 2'b00);
      end
      step();
      exp = {1'b1, 3'(i), 8'h00, (i == 7)};
      n_checks++;
      if (wr_obs !== exp) begin
        n_fail++; $display("FAIL init_sweep[%0d]: got %h expected %h", i, wr_obs, exp);
      end
    end
    bus.A_VALID = 1'b0;
    bus.M_VALID = 1'b0;
    step();
    n_checks++;
    if ({bus.WRITE, bus.INIT_DONE} !== 2'b01) begin
      n_fail++; $display("FAIL post_init_idle: got %b expected %b", {bus.WRITE, bus.INIT_DONE}, 2'b01);
    end
  endtask

  task automatic test_single();
    bus.OUT1ADDRESS = 3'd3;
    bus.OUT2ADDRESS = 3'd6;
    bus.A_VALID = 1'b1; bus.A_ADDR = 3'd3; bus.A_DATA = 8'h5A;
    #1;
    n_checks++;
    if (rdy_obs !== 2'b10) begin
      n_fail++; $display("FAIL a_only_ready: got %b expected %b", rdy_obs, 2'b10);
    end
    n_checks++;
    if (fwd_obs !== 2'b00) begin
      n_fail++; $display("FAIL fwd_idle: got %b expected %b", fwd_obs, 2'b00);
    end
    step();
    bus.A_VALID = 1'b0;
    n_checks++;
    if (wr_obs !== {1'b1, 3'd3, 8'h5A, 1'b1}) begin
      n_fail++; $display("FAIL a_only_write: got %h expected %h", wr_obs, {1'b1, 3'd3, 8'h5A, 1'b1});
    end
    n_checks++;
    if (fwd_obs !== 2'b10) begin
      n_fail++; $display("FAIL a_only_fwd1: got %b expected %b", fwd_obs, 2'b10);
    end

    bus.M_VALID = 1'b1; bus.M_ADDR = 3'd6; bus.M_DATA = 8'hC3;
    #1;
    n_checks++;
    if (rdy_obs !== 2'b01) begin
      n_fail++; $display("FAIL m_only_ready: got %b expected %b", rdy_obs, 2'b01);
    end
    step();
    bus.M_VALID = 1'b0;
    n_checks++;
    if (wr_obs !== {1'b1, 3'd6, 8'hC3, 1'b1}) begin
      n_fail++; $display("FAIL m_only_write: got %h expected %h", wr_obs, {1'b1, 3'd6, 8'hC3, 1'b1});
    end
    n_checks++;
    if (fwd_obs !== 2'b01) begin
      n_fail++; $display("FAIL m_only_fwd2: got %b expected %b", fwd_obs, 2'b01);
    end
    step();
    n_checks++;
    if (wr_obs !== {1'b0, 3'd6, 8'hC3, 1'b1}) begin
      n_fail++; $display("FAIL idle_hold: got %h expected %h", wr_obs, {1'b0, 3'd6, 8'hC3, 1'b1});
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] exp_m;
    logic [7:0] a_data;
    logic [7:0] m_data;
    exp_m  = 8'b1000_1000;  // bit i set: cycle i grants M
    a_data = 8'h10;
    m_data = 8'h80;
    bus.A_ADDR = 3'd1; bus.M_ADDR = 3'd2;
    bus.A_VALID = 1'b1; bus.M_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.A_DATA = a_data;
      bus.M_DATA = m_data;
      #1;
      n_checks++;
      if (rdy_obs !== (exp_m[i] ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL arb_grant[%0d]: got %b expected %b", i, rdy_obs, (exp_m[i] ? 2'b01 : 2'b10));
      end
      step();
      if (exp_m[i]) begin
        n_checks++;
        if (wr_obs !== {1'b1, 3'd2, m_data, 1'b1}) begin
          n_fail++; $display("FAIL arb_write_m[%0d]: got %h expected %h", i, wr_obs, {1'b1, 3'd2, m_data, 1'b1});
        end
        m_data = m_data + 8'd1;
      end else begin
        n_checks++;
        if (wr_obs !== {1'b1, 3'd1, a_data, 1'b1}) begin
          n_fail++; $display("FAIL arb_write_a[%0d]: got %h expected %h", i, wr_obs, {1'b1, 3'd1, a_data, 1'b1});
        end
        a_data = a_data + 8'd1;
      end
    end
    bus.A_VALID = 1'b0;
    bus.M_VALID = 1'b0;
  endtask

  task automatic test_busywait();
    logic [2:0] exp_m;
    logic [7:0] a_data;
    exp_m = 3'b100;
    // Age is 0 here (last grant was M); one A win brings it to 1.
    bus.OUT1ADDRESS = 3'd5;
    bus.OUT2ADDRESS = 3'd6;
    bus.A_VALID = 1'b1; bus.A_ADDR = 3'd5; bus.A_DATA = 8'h55;
    bus.M_VALID = 1'b1; bus.M_ADDR = 3'd7; bus.M_DATA = 8'hE0;
    #1;
    n_checks++;
    if (rdy_obs !== 2'b10) begin
      n_fail++; $display("FAIL pre_stall_grant: got %b expected %b", rdy_obs, 2'b10);
    end
    step();
    a_data = 8'h40;
    bus.A_ADDR = 3'd4; bus.A_DATA = a_data;
    bus.BUSYWAIT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (rdy_obs !== 2'b00) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b expected %b", i, rdy_obs, 2'b00);
      end
      step();
      n_checks++;
      if (wr_obs !== {1'b1, 3'd5, 8'h55, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, wr_obs, {1'b1, 3'd5, 8'h55, 1'b1});
      end
      n_checks++;
      if (fwd_obs !== 2'b10) begin
        n_fail++; $display("FAIL stall_fwd[%0d]: got %b expected %b", i, fwd_obs, 2'b10);
      end
    end
    bus.BUSYWAIT = 1'b0;
    // Age resumes at 1: A, A, then M is forced.
    for (int i = 0; i < 3; i++) begin
      bus.A_DATA = a_data;
      #1;
      n_checks++;
      if (rdy_obs !== (exp_m[i] ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL resume_grant[%0d]: got %b expected %b", i, rdy_obs, (exp_m[i] ? 2'b01 : 2'b10));
      end
      step();
      if (exp_m[i]) begin
        n_checks++;
        if (wr_obs !== {1'b1, 3'd7, 8'hE0, 1'b1}) begin
          n_fail++; $display("FAIL resume_write_m[%0d]: got %h expected %h", i, wr_obs, {1'b1, 3'd7, 8'hE0, 1'b1});
        end
      end else begin
        n_checks++;
        if (wr_obs !== {1'b1, 3'd4, a_data, 1'b1}) begin
          n_fail++; $display("FAIL resume_write_a[%0d]: got %h expected %h", i, wr_obs, {1'b1, 3'd4, a_data, 1'b1});
        end
        a_data = a_data + 8'd1;
      end
    end
    bus.A_VALID = 1'b0;
    bus.M_VALID = 1'b0;
  endtask

  task automatic test_ibusy_init();
    logic [12:0] exp;
    int          exp_addr;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      bus.IBUSYWAIT = (e == 5) || (e == 6);
      step();
      if (e <= 4)      exp_addr = e - 1;
      else if (e <= 6) exp_addr = 3;
      else             exp_addr = e - 3;
      exp = {1'b1, 3'(exp_addr), 8'h00, (e == 10)};
      n_checks++;
      if (wr_obs !== exp) begin
        n_fail++; $display("FAIL ibusy_sweep[edge %0d]: got %h expected %h", e, wr_obs, exp);
      end
    end
    bus.IBUSYWAIT = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [12:0] exp;
    bus.A_VALID = 1'b1; bus.A_ADDR = 3'd6; bus.A_DATA = 8'h9C;
    #1;
    n_checks++;
    if (rdy_obs !== 2'b10) begin
      n_fail++; $display("FAIL pre_reset_grant: got %b expected %b", rdy_obs, 2'b10);
    end
    step();
    bus.A_VALID = 1'b0;
    n_checks++;
    if (wr_obs !== {1'b1, 3'd6, 8'h9C, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset_write: got %h expected %h", wr_obs, {1'b1, 3'd6, 8'h9C, 1'b1});
    end
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (wr_obs !== 13'h0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h expected %h", wr_obs, 13'h0);
    end
    bus.A_VALID = 1'b1;
    #1;
    n_checks++;
    if (rdy_obs !== 2'b00) begin
      n_fail++; $display("FAIL reset_no_ack: got %b expected %b", rdy_obs, 2'b00);
    end
    bus.A_VALID = 1'b0;
    step();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp = {1'b1, 3'(i), 8'h00, (i == 7)};
      n_checks++;
      if (wr_obs !== exp) begin
        n_fail++; $display("FAIL restart_sweep[%0d]: got %h expected %h", i, wr_obs, exp);
      end
    end
  endtask

  initial begin
    RESET           = 1'b1;
    bus.BUSYWAIT    = 1'b0;
    bus.IBUSYWAIT   = 1'b0;
    bus.A_VALID     = 1'b0;
    bus.A_ADDR      = '0;
    bus.A_DATA      = '0;
    bus.M_VALID     = 1'b0;
    bus.M_ADDR      = '0;
    bus.M_DATA      = '0;
    bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0;

    test_reset();
    test_single();
    test_arbitration();
    test_busywait();
    test_ibusy_init();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Owns the single write port of the 8x8 register file.
- After reset, sequences a clear of every register to INIT_VALUE.
- Then arbitrates the write port between the ALU writeback requester (A) and the data-memory load requester (M), using ALU priority with an anti-starvation age counter.
- Freezes while either memory is busy, and flags read ports whose address matches the write presented this cycle.

Parameters:
- DATA_WIDTH, 8, width of register data.
- ADDR_WIDTH, 3, register address width; NREGS = 2**ADDR_WIDTH.
- AGE_LIMIT, 3, consecutive ALU wins over a waiting M before M is forced.
- INIT_VALUE, 0, value written to every register during init.

Ports:
- Interface decision: one clock, CLK. RESET is asynchronous and active-high.
- CLK  in  1  clock, all state updates on the posedge.
- RESET  in  1  asynchronous, active-high reset.
- BUSYWAIT  in  1  data-memory stall.
- IBUSYWAIT  in  1  instruction-memory stall.
- A_VALID  in  1  ALU write request.
- A_ADDR  in  ADDR_WIDTH  ALU destination register.
- A_DATA  in  DATA_WIDTH  ALU result.
- A_READY  out  1  ALU request accepted this cycle.
- M_VALID  in  1  load write request.
- M_ADDR  in  ADDR_WIDTH  load destination register.
- M_DATA  in  DATA_WIDTH  load data.
- M_READY  out  1  load request accepted this cycle.
- WRITE  out  1  register-file write enable (registered).
- INADDRESS  out  ADDR_WIDTH  register-file write address (registered).
- IN  out  DATA_WIDTH  register-file write data (registered).
- INIT_DONE  out  1  high once the init sweep has been issued.
- OUT1ADDRESS  in  ADDR_WIDTH  register-file read port 1 address.
- OUT2ADDRESS  in  ADDR_WIDTH  register-file read port 2 address.
- FWD1  out  1  WRITE && INADDRESS==OUT1ADDRESS (combinational).
- FWD2  out  1  WRITE && INADDRESS==OUT2ADDRESS (combinational).

Behaviour:
- stall = BUSYWAIT | IBUSYWAIT.
  - On a stalled posedge, all state holds: outputs, state, counters and age.
  - A_READY and M_READY are 0 during stall.
- RESET (asynchronous) forces:
  - state=INIT, init_cnt=0, age=0;
  - WRITE=0, INADDRESS=0, IN=0, INIT_DONE=0.
  - A_READY and M_READY are 0 while in INIT.
- INIT state, on each non-stalled posedge:
  - WRITE<=1, INADDRESS<=init_cnt, IN<=INIT_VALUE, init_cnt++.
  - On the edge that issues address NREGS-1: state<=RUN, INIT_DONE<=1.
  - Unstalled, this takes edges 1..8 after reset deassertion; INIT_DONE is high from edge 8.
- RUN state, grant is combinational, computed only when not stalled:
  - only A_VALID -> grant A;
  - only M_VALID -> grant M;
  - both valid -> grant M if age==AGE_LIMIT, else grant A.
  - A_READY = grant A; M_READY = grant M. A transfer completes on the posedge where VALID&&READY.
- Output register on a non-stalled RUN posedge:
  - with a grant: WRITE<=1, INADDRESS<=granted ADDR, IN<=granted DATA;
  - without a grant: WRITE<=0; INADDRESS and IN hold.
- Latency: accepted request -> WRITE high the next cycle -> register file commits on the following non-stalled edge.
- Age counter, on non-stalled RUN edges:
  - both valid and A granted -> age++ (saturate at AGE_LIMIT);
  - M granted, or M_VALID low -> age<=0.
- Requester contract: VALID, ADDR and DATA stay stable until READY. The block has no buffering; it never drops or duplicates a request.
- Same-address requests in the same cycle are not merged. They are written in grant order, so the later grant's data persists.
- RESET mid-INIT or mid-RUN: immediate return to reset values and restart of the init sweep. Requests outstanding at reset are not acknowledged.
- FWD1/FWD2 are pure combinational compares. Their reset value is 0, since WRITE=0.

Test Plan:
- Reset, no stall, no requests:
  - -> WRITE=1 with INADDRESS 0..7, IN=0 on edges 1..8; INIT_DONE=1 after edge 8;
  - -> WRITE=0 thereafter; READYs 0 throughout INIT.
- RUN, A_VALID only, A_ADDR=3, A_DATA=0x5A:
  - -> A_READY=1 in the same cycle; next cycle WRITE=1, INADDRESS=3, IN=0x5A;
  - -> FWD1=1 when OUT1ADDRESS=3.
- Both requesters valid continuously, AGE_LIMIT=3:
  - -> grant sequence A,A,A,M,A,A,A,M;
  - -> age resets after each M grant.
- Raise BUSYWAIT for 4 cycles while WRITE=1, INADDRESS=5:
  - -> outputs, age and READYs frozen (READYs 0);
  - -> on release, the sequence resumes without loss or duplication.
- Assert IBUSYWAIT during INIT at init_cnt=4 for 2 cycles:
  - -> the sweep pauses at INADDRESS=3 and resumes 4..7;
  - -> INIT_DONE is delayed by 2 cycles.
- Assert RESET asynchronously mid-RUN with WRITE=1:
  - -> WRITE, INADDRESS, IN and INIT_DONE go to 0 immediately, without waiting for a clock edge;
  - -> the init sweep restarts from address 0.
